d_ff: RTL and testbench

- Single-bit-per-lane, positive-edge D flip-flop with complementary outputs.
- Has a synchronous active-high set and an asynchronous active-low reset.
- Parameterised width, so one instance can register a bus of independent lanes that share clock, set and reset.
- Used as the basic storage element in sequential logic blocks and as a reference cell for flip-flop verification.

---
 rtl/d_ff.sv | 38 +++
 tb/tb_d_ff.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/d_ff.sv
// Positive-edge D flip-flop bank with complementary outputs, synchronous
// active-high set and asynchronous active-low reset shared across all lanes.
module d_ff #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SET_VALUE   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             set,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] qd,
  output logic [WIDTH-1:0] qb
);

  logic [WIDTH-1:0] qd_q;
  logic [WIDTH-1:0] qd_d;

  // Set takes priority over data capture
  always_comb begin
    qd_d = D;
    if (set) begin
      qd_d = SET_VALUE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qd_q <= RESET_VALUE;
    end else begin
      qd_q <= qd_d;
    end
  end

  assign qd = qd_q;
  assign qb = ~qd_q;

endmodule

// File: tb/tb_d_ff.sv
// Directed bench for d_ff: a 1-bit default instance and a 4-bit instance
// with non-zero reset value, sharing clock, set and reset.
module tb_d_ff;

  logic       clk;
  logic       reset_n;
  logic       set;
  logic [0:0] d_n;
  logic [0:0] qd_n;
  logic [0:0] qb_n;
  logic [3:0] d_w;
  logic [3:0] qd_w;
  logic [3:0] qb_w;

  int n_checks;
  int n_fail;
  bit mon_en;

  d_ff u_dut_n (
    .clk     (clk),
    .reset_n (reset_n),
    .set     (set),
    .D       (d_n),
    .qd      (qd_n),
    .qb      (qb_n)
  );

  d_ff #(
    .WIDTH       (4),
    .RESET_VALUE (4'b1010)
  ) u_dut_w (
    .clk     (clk),
    .reset_n (reset_n),
    .set     (set),
    .D       (d_w),
    .qd      (qd_w),
    .qb      (qb_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       set;
    logic [0:0] d_n;
    logic [0:0] exp_n;
    logic [3:0] d_w;
    logic [3:0] exp_w;
  } vec_t;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Checks both instances' true and complement outputs against expectations
  task automatic check_all(input string name, input logic [0:0] en, input logic [3:0] ew);
    check({name, "_qd_n"}, {3'b000, qd_n}, {3'b000, en});
    check({name, "_qb_n"}, {3'b000, qb_n}, {3'b000, ~en});
    check({name, "_qd_w"}, qd_w, ew);
    check({name, "_qb_w"}, qb_w, ~ew);
  endtask

  // Complement invariant sampled every cycle once reset has been applied
  always @(negedge clk) begin
    if (mon_en) begin
      check("inv_n", {3'b000, qb_n}, {3'b000, ~qd_n});
      check("inv_w", qb_w, ~qd_w);
    end
  end

  initial begin
    vec_t       vecs[7];
    logic [0:0] prev_n;
    logic [3:0] prev_w;

    vecs[0] = '{1'b0, 1'b1, 1'b1, 4'b0011, 4'b0011};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 4'b1100, 4'b1100};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 4'b0000, 4'b1111};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 4'b0101, 4'b1111};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 4'b1010, 4'b1111};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 4'b0110, 4'b0110};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 4'b1001, 4'b1001};

    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    reset_n  = 1'b1;
    set      = 1'b0;
    d_n      = 1'b1;
    d_w      = 4'b1111;

    // Async reset with D high, before the first clock edge
    #1 reset_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 4'b1010);
    mon_en = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_all("rst_held", 1'b0, 4'b1010);

    // Release mid-cycle: no capture until the next edge
    @(negedge clk);
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    #1;
    check_all("rel_noclk", 1'b0, 4'b1010);
    @(posedge clk);
    #1;
    check_all("rel_edge", 1'b1, 4'b1111);

    prev_n = 1'b1;
    prev_w = 4'b1111;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      set = vecs[i].set;
      d_n = vecs[i].d_n;
      d_w = vecs[i].d_w;
      #1;
      check_all($sformatf("vec%0d_hold", i), prev_n, prev_w);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d_edge", i), vecs[i].exp_n, vecs[i].exp_w);
      prev_n = vecs[i].exp_n;
      prev_w = vecs[i].exp_w;
    end

    // D and set changes between edges do not disturb the state
    d_n = 1'b0;
    d_w = 4'b0000;
    #2;
    check_all("d_toggle", 1'b1, 4'b1001);
    set = 1'b1;
    #1;
    check_all("set_mid", 1'b1, 4'b1001);
    @(posedge clk);
    #1;
    check_all("set_edge", 1'b1, 4'b1111);

    // Reset overrides set, including across clock edges
    d_n = 1'b1;
    d_w = 4'b0110;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_all("rst_over_set", 1'b0, 4'b1010);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("rst_set_edge%0d", k), 1'b0, 4'b1010);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_all("rst_set_rel", 1'b0, 4'b1010);
    @(posedge clk);
    #1;
    check_all("rst_set_after", 1'b1, 4'b1111);

    // Set released: data capture resumes
    @(negedge clk);
    set = 1'b0;
    d_n = 1'b0;
    d_w = 4'b0011;
    @(posedge clk);
    #1;
    check_all("set_rel", 1'b0, 4'b0011);

    repeat (2) @(posedge clk);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
